// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, tags each
// with its PC, and buffers returned words in a small FIFO for the decode controller.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic [6:0]  func7
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_reg,    fetch_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] kill_reg,        kill_next;
  logic [CW-1:0] fifo_count_reg,  fifo_count_next;
  logic [PW-1:0] tag_wr_ptr_reg,  tag_wr_ptr_next;
  logic [PW-1:0] tag_rd_ptr_reg,  tag_rd_ptr_next;
  logic [PW-1:0] fifo_wr_ptr_reg, fifo_wr_ptr_next;
  logic [PW-1:0] fifo_rd_ptr_reg, fifo_rd_ptr_next;

  logic [31:0] tag_mem       [DEPTH];
  logic [31:0] fifo_word_mem [DEPTH];
  logic [31:0] fifo_pc_mem   [DEPTH];

  logic          pop;
  logic          grant;
  logic          resp;
  logic          resp_kill;
  logic          push;
  logic [CW:0]   credit;
  logic [31:0]   resp_pc;

  // Handshake decode
  assign instr_valid = (fifo_count_reg != '0);
  assign pop         = instr_valid && instr_ready;
  assign credit      = (CW+1)'(outstanding_reg) + (CW+1)'(fifo_count_reg) - (CW+1)'(pop);
  assign imem_req    = rst_n && (credit < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc_reg;
  assign grant       = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign resp        = imem_rvalid && (outstanding_reg != '0);
  assign resp_kill   = resp && (kill_reg != '0);
  assign push        = resp && !resp_kill;
  assign resp_pc     = tag_mem[tag_rd_ptr_reg];

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    outstanding_next = outstanding_reg + CW'(grant) - CW'(resp);
    kill_next        = kill_reg - CW'(resp_kill);
    tag_wr_ptr_next  = tag_wr_ptr_reg + PW'(grant);
    tag_rd_ptr_next  = tag_rd_ptr_reg + PW'(resp);
    fifo_count_next  = fifo_count_reg + CW'(push) - CW'(pop);
    fifo_wr_ptr_next = fifo_wr_ptr_reg + PW'(push);
    fifo_rd_ptr_next = fifo_rd_ptr_reg + PW'(pop);

    if (grant) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end

    // Every response still in flight after this edge belongs to the old path.
    if (redirect) begin
      fetch_pc_next    = {redirect_target[31:2], 2'b00};
      kill_next        = outstanding_next;
      fifo_count_next  = '0;
      fifo_wr_ptr_next = '0;
      fifo_rd_ptr_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      kill_reg        <= '0;
      fifo_count_reg  <= '0;
      tag_wr_ptr_reg  <= '0;
      tag_rd_ptr_reg  <= '0;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      kill_reg        <= kill_next;
      fifo_count_reg  <= fifo_count_next;
      tag_wr_ptr_reg  <= tag_wr_ptr_next;
      tag_rd_ptr_reg  <= tag_rd_ptr_next;
      fifo_wr_ptr_reg <= fifo_wr_ptr_next;
      fifo_rd_ptr_reg <= fifo_rd_ptr_next;
    end
  end

  // Per-slot storage; occupancy is tracked by the counters, so no reset is needed.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [31:0] tag_q;
    logic [31:0] word_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
      if (grant && (tag_wr_ptr_reg == PW'(gi))) begin
        tag_q <= fetch_pc_reg;
      end
      if (push && (fifo_wr_ptr_reg == PW'(gi))) begin
        word_q <= imem_rdata;
        pc_q   <= resp_pc;
      end
    end

    assign tag_mem[gi]       = tag_q;
    assign fifo_word_mem[gi] = word_q;
    assign fifo_pc_mem[gi]   = pc_q;
  end

  assign instr    = instr_valid ? fifo_word_mem[fifo_rd_ptr_reg] : NOP;
  assign instr_pc = instr_valid ? fifo_pc_mem[fifo_rd_ptr_reg]   : 32'h0;
  assign op       = instr[6:0];
  assign func3    = instr[14:12];
  assign func7    = instr[31:25];

  a_no_orphan_response: assert property (
    @(posedge clk) disable iff (!rst_n) !(imem_rvalid && (outstanding_reg == '0))
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order memory with per-request latency and an
// epoch-tagged program-order model predict every output each cycle.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [6:0]  func7;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .op              (op),
    .func3           (func3),
    .func7           (func7)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epoch = 0;
  int fixed_lat = 1;
  bit rand_lat = 1'b0;
  string phase = "init";

  // Memory side: requests in flight, in order, with due cycle and path epoch.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          mq_epoch[$];
  // Program-order view of buffered instructions (PCs only; words derive from PC).
  logic [31:0] mf_pc[$];
  logic [31:0] exp_fetch_pc = RST_PC;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], 16'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_addr.delete();
    mq_due.delete();
    mq_epoch.delete();
    mf_pc.delete();
    exp_fetch_pc = RST_PC;
  endtask

  task automatic check_reset_outputs();
    chk("rst_req",   {31'b0, imem_req},    32'h0);
    chk("rst_addr",  imem_addr,            RST_PC);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr,                NOP);
    chk("rst_pc",    instr_pc,             32'h0);
    chk("rst_op",    {25'b0, op},          32'h13);
  endtask

  task automatic quiet_inputs();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    instr_ready = 1'b0;
  endtask

  // Leaves the bench at posedge+1 with rst_n just released.
  task automatic apply_reset();
    rst_n = 1'b0;
    quiet_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
  endtask

  // Reset asserted between clock edges: outputs must clear without a clock.
  task automatic async_reset_mid();
    quiet_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req",   {31'b0, imem_req},    32'h0);
    chk("async_valid", {31'b0, instr_valid}, 32'h0);
    chk("async_instr", instr,                NOP);
    chk("async_pc",    instr_pc,             32'h0);
    chk("async_addr",  imem_addr,            RST_PC);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs at posedge+1, check at posedge+2, advance model.
  task automatic step(input bit rdy, input bit gnt_en, input bit redir, input logic [31:0] tgt);
    bit          exp_req;
    bit          exp_valid;
    bit          pop;
    bit          grant;
    bit          resp;
    logic [31:0] exp_instr;
    logic [31:0] exp_ipc;
    int          credit;
    int          lat;

    instr_ready = rdy;
    imem_gnt = gnt_en;
    redirect = redir;
    redirect_target = tgt;
    resp = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
    imem_rvalid = resp;
    imem_rdata = resp ? mem_fn(mq_addr[0]) : $urandom;

    exp_valid = (mf_pc.size() > 0);
    exp_instr = exp_valid ? mem_fn(mf_pc[0]) : NOP;
    exp_ipc   = exp_valid ? mf_pc[0] : 32'h0;
    pop       = exp_valid && rdy;
    credit    = mq_addr.size() + mf_pc.size() - int'(pop);
    exp_req   = (credit < DEPTH);

    #1;
    chk("imem_req",    {31'b0, imem_req},    {31'b0, exp_req});
    chk("imem_addr",   imem_addr,            exp_fetch_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    chk("instr",       instr,                exp_instr);
    chk("instr_pc",    instr_pc,             exp_ipc);
    chk("op",          {25'b0, op},          {25'b0, exp_instr[6:0]});
    chk("func3",       {29'b0, func3},       {29'b0, exp_instr[14:12]});
    chk("func7",       {25'b0, func7},       {25'b0, exp_instr[31:25]});

    grant = exp_req && gnt_en;
    if (pop) void'(mf_pc.pop_front());
    if (resp) begin
      if (mq_epoch[0] == epoch) mf_pc.push_back(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      void'(mq_epoch.pop_front());
    end
    if (grant) begin
      lat = rand_lat ? int'($urandom_range(4, 1)) : fixed_lat;
      mq_addr.push_back(exp_fetch_pc);
      mq_due.push_back(cyc + lat);
      mq_epoch.push_back(epoch);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    if (redir) begin
      epoch++;
      mf_pc.delete();
      exp_fetch_pc = {tgt[31:2], 2'b00};
    end

    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    // Reset and streaming with 1-cycle memory
    phase = "stream";
    fixed_lat = 1;
    rand_lat = 1'b0;
    #3;
    apply_reset();
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Backpressure from a fresh start, then drain
    phase = "backpressure";
    apply_reset();
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with two requests in flight (3-cycle memory)
    phase = "redirect_inflight";
    apply_reset();
    fixed_lat = 3;
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
    fixed_lat = 1;
    step(1'b1, 1'b1, 1'b1, 32'h0000_2002);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect in the same cycle as a grant and a response
    phase = "redirect_collide";
    apply_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_3000);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Address wrap and empty-FIFO outputs
    phase = "wrap";
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomised traffic with variable latency and random redirects
    phase = "random";
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7,
           $urandom_range(19, 0) == 0, $urandom);
    end

    // Asynchronous reset in the middle of traffic, then resume
    phase = "async_reset";
    async_reset_mid();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(9, 0) < 8, $urandom_range(9, 0) < 6,
           $urandom_range(29, 0) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
